// File: rtl/cmu_sched.sv
// Shares one cmu packet allocator between NUM_PORTS round-robin ingress requesters
// and a single egress free path that walks and returns linked block chains.
module cmu_sched #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned LEN_W     = 6,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned FREE_INIT = 63,
    parameter int unsigned BLK_GAP   = 4,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        done,
    output logic [ADDR_W-1:0]           done_addr,
    input  logic                        free_req,
    input  logic [ADDR_W-1:0]           free_addr,
    output logic                        free_ack,
    output logic [LEN_W-1:0]            free_count,
    output logic                        cmu_wen,
    output logic [LEN_W-1:0]            cmu_len,
    output logic                        cmu_free_en,
    output logic [ADDR_W-1:0]           cmu_raddr,
    input  logic [ADDR_W-1:0]           cmu_packet_addr,
    input  logic [ADDR_W-1:0]           cmu_next_read
);
    localparam int unsigned PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_MAX = (BLK_GAP > RD_LAT) ? BLK_GAP : RD_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, ALLOC, ALLOC_GAP, DONE, FREE_RD, FREE_WAIT, FREE_ACK
    } state_e;

    state_e                state_q, state_d;
    logic [PORT_W-1:0]     rr_q, rr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [ADDR_W-1:0]     head_q, head_d;
    logic                  first_q, first_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]  grant_q, grant_d;
    logic                  done_q, done_d;
    logic [ADDR_W-1:0]     done_addr_q, done_addr_d;
    logic                  free_ack_q, free_ack_d;
    logic [LEN_W-1:0]      free_count_q, free_count_d;
    logic                  cmu_wen_q, cmu_wen_d;
    logic [LEN_W-1:0]      cmu_len_q, cmu_len_d;
    logic                  cmu_free_en_q, cmu_free_en_d;
    logic [ADDR_W-1:0]     cmu_raddr_q, cmu_raddr_d;

    logic [LEN_W-1:0]      len_a [NUM_PORTS];
    logic [NUM_PORTS-1:0]  elig;
    logic                  pick_found;
    logic [PORT_W-1:0]     pick_idx;

    function automatic logic [PORT_W-1:0] wrap_idx(input logic [31:0] v);
        return PORT_W'(v % NUM_PORTS);
    endfunction

    // Round-robin pick of the first port whose request fits in the free pool.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            len_a[i] = req_len[i*LEN_W +: LEN_W];
            elig[i]  = req[i] && (len_a[i] != '0) && (len_a[i] <= free_count_q);
        end
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!pick_found && elig[wrap_idx(32'(rr_q) + k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(32'(rr_q) + k);
            end
        end
    end

    // Next-state logic; strobes are computed one cycle early so they register into the target state.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        rem_d         = rem_q;
        head_d        = head_q;
        first_d       = first_q;
        cnt_d         = '0;
        grant_d       = grant_q;
        done_d        = 1'b0;
        done_addr_d   = done_addr_q;
        free_ack_d    = 1'b0;
        free_count_d  = free_count_q;
        cmu_wen_d     = 1'b0;
        cmu_len_d     = '0;
        cmu_free_en_d = 1'b0;
        cmu_raddr_d   = cmu_raddr_q;

        case (state_q)
            IDLE: begin
                if (free_req) begin
                    state_d       = FREE_RD;
                    cmu_free_en_d = 1'b1;
                    cmu_raddr_d   = free_addr;
                end else if (pick_found) begin
                    state_d   = ALLOC;
                    grant_d   = NUM_PORTS'(1) << pick_idx;
                    rr_d      = wrap_idx(32'(pick_idx) + 32'd1);
                    rem_d     = len_a[pick_idx];
                    first_d   = 1'b1;
                    cmu_wen_d = 1'b1;
                    cmu_len_d = len_a[pick_idx];
                end
            end
            ALLOC: begin
                if (first_q) begin
                    head_d = cmu_packet_addr;
                end
                first_d = 1'b0;
                if (free_count_q != '0) begin
                    free_count_d = free_count_q - LEN_W'(1);
                end
                if (rem_q != '0) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                state_d = ALLOC_GAP;
            end
            ALLOC_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BLK_GAP - 2)) begin
                    cnt_d = '0;
                    if (rem_q != '0) begin
                        state_d   = ALLOC;
                        cmu_wen_d = 1'b1;
                        cmu_len_d = rem_q;
                    end else begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        done_addr_d = head_q;
                    end
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            FREE_RD: begin
                if (free_count_q < LEN_W'(FREE_INIT)) begin
                    free_count_d = free_count_q + LEN_W'(1);
                end
                state_d = FREE_WAIT;
            end
            FREE_WAIT: begin
                // cmu_raddr_q doubles as the walk register while the link read settles.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    cnt_d = '0;
                    if (cmu_next_read == '0) begin
                        state_d    = FREE_ACK;
                        free_ack_d = 1'b1;
                    end else begin
                        state_d       = FREE_RD;
                        cmu_free_en_d = 1'b1;
                        cmu_raddr_d   = cmu_next_read;
                    end
                end
            end
            FREE_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            rem_q         <= '0;
            head_q        <= '0;
            first_q       <= 1'b0;
            cnt_q         <= '0;
            grant_q       <= '0;
            done_q        <= 1'b0;
            done_addr_q   <= '0;
            free_ack_q    <= 1'b0;
            free_count_q  <= LEN_W'(FREE_INIT);
            cmu_wen_q     <= 1'b0;
            cmu_len_q     <= '0;
            cmu_free_en_q <= 1'b0;
            cmu_raddr_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            rem_q         <= rem_d;
            head_q        <= head_d;
            first_q       <= first_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            done_addr_q   <= done_addr_d;
            free_ack_q    <= free_ack_d;
            free_count_q  <= free_count_d;
            cmu_wen_q     <= cmu_wen_d;
            cmu_len_q     <= cmu_len_d;
            cmu_free_en_q <= cmu_free_en_d;
            cmu_raddr_q   <= cmu_raddr_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign done_addr   = done_addr_q;
    assign free_ack    = free_ack_q;
    assign free_count  = free_count_q;
    assign cmu_wen     = cmu_wen_q;
    assign cmu_len     = cmu_len_q;
    assign cmu_free_en = cmu_free_en_q;
    assign cmu_raddr   = cmu_raddr_q;
endmodule

// File: tb/tb_cmu_sched.sv
// Bench for cmu_sched: transaction-schedule reference model, directed scenarios, random traffic.
module tb_cmu_sched;
    localparam int NP        = 4;
    localparam int LEN_W     = 6;
    localparam int ADDR_W    = 10;
    localparam int FREE_INIT = 63;
    localparam int BLK_GAP   = 4;
    localparam int RD_LAT    = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NP-1:0]          req;
    logic [NP*LEN_W-1:0]    req_len;
    logic [NP-1:0]          grant;
    logic                   done;
    logic [ADDR_W-1:0]      done_addr;
    logic                   free_req;
    logic [ADDR_W-1:0]      free_addr;
    logic                   free_ack;
    logic [LEN_W-1:0]       free_count;
    logic                   cmu_wen;
    logic [LEN_W-1:0]       cmu_len;
    logic                   cmu_free_en;
    logic [ADDR_W-1:0]      cmu_raddr;
    logic [ADDR_W-1:0]      cmu_packet_addr;
    logic [ADDR_W-1:0]      cmu_next_read;

    int checks = 0;
    int errors = 0;

    cmu_sched #(
        .NUM_PORTS(NP), .LEN_W(LEN_W), .ADDR_W(ADDR_W),
        .FREE_INIT(FREE_INIT), .BLK_GAP(BLK_GAP), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .grant(grant),
        .done(done), .done_addr(done_addr), .free_req(free_req), .free_addr(free_addr),
        .free_ack(free_ack), .free_count(free_count), .cmu_wen(cmu_wen), .cmu_len(cmu_len),
        .cmu_free_en(cmu_free_en), .cmu_raddr(cmu_raddr), .cmu_packet_addr(cmu_packet_addr),
        .cmu_next_read(cmu_next_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Link memory of the cmu, read with RD_LAT cycles of latency.
    logic [ADDR_W-1:0] link [1024];
    logic [ADDR_W-1:0] rd_pipe = '0;
    initial cmu_next_read = '0;
    always @(posedge clk) begin
        rd_pipe       <= link[cmu_raddr];
        cmu_next_read <= rd_pipe;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each transaction is a schedule indexed by its cycle number j.
    int                 m_kind;   // 0 idle, 1 allocation, 2 free walk
    int                 m_j, m_len, m_port, m_rr, m_fc, m_p, m_l;
    logic [ADDR_W-1:0]  m_head, m_a;
    int                 chain[$];
    logic [NP-1:0]      e_grant;
    logic               e_wen, e_free_en, e_done, e_free_ack;
    int                 e_len, e_fc;
    logic [ADDR_W-1:0]  e_raddr, e_done_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind = 0; m_j = 0; m_len = 0; m_port = 0; m_rr = 0; m_fc = FREE_INIT;
            m_head = '0; chain.delete();
            e_grant = '0; e_wen = 0; e_free_en = 0; e_done = 0; e_free_ack = 0;
            e_len = 0; e_fc = FREE_INIT; e_raddr = '0; e_done_addr = '0;
        end else begin
            if (m_kind == 1) begin
                if (m_j == 1) m_head = cmu_packet_addr;
                if (e_wen) m_fc--;
                if (m_j == BLK_GAP * m_len + 1) m_kind = 0;
            end else if (m_kind == 2) begin
                if (e_free_en && m_fc < FREE_INIT) m_fc++;
                if (m_j == (1 + RD_LAT) * chain.size() + 1) m_kind = 0;
            end else if (free_req) begin
                chain.delete();
                m_a = free_addr;
                for (int g = 0; g < 1024; g++) begin
                    chain.push_back(int'(m_a));
                    if (link[m_a] == '0) break;
                    m_a = link[m_a];
                end
                m_kind = 2; m_j = 0;
            end else begin
                for (int k = 0; k < NP; k++) begin
                    m_p = (m_rr + k) % NP;
                    m_l = int'(req_len[m_p*LEN_W +: LEN_W]);
                    if (req[m_p] && m_l > 0 && m_l <= m_fc) begin
                        m_kind = 1; m_j = 0; m_port = m_p; m_len = m_l;
                        m_rr = (m_p + 1) % NP;
                        break;
                    end
                end
            end
            e_grant = '0; e_wen = 0; e_len = 0; e_free_en = 0; e_done = 0; e_free_ack = 0;
            if (m_kind == 1) begin
                m_j++;
                e_grant = NP'(1) << m_port;
                if (m_j <= BLK_GAP * m_len && (m_j - 1) % BLK_GAP == 0) begin
                    e_wen = 1;
                    e_len = m_len - (m_j - 1) / BLK_GAP;
                end
                if (m_j == BLK_GAP * m_len + 1) begin
                    e_done = 1;
                    e_done_addr = m_head;
                end
            end else if (m_kind == 2) begin
                m_j++;
                if (m_j <= (1 + RD_LAT) * chain.size()) begin
                    e_raddr   = ADDR_W'(chain[(m_j - 1) / (1 + RD_LAT)]);
                    e_free_en = ((m_j - 1) % (1 + RD_LAT) == 0);
                end else begin
                    e_free_ack = 1;
                end
            end
            e_fc = m_fc;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("grant", grant, e_grant);
            chk("cmu_wen", cmu_wen, e_wen);
            chk("cmu_len", cmu_len, e_len);
            chk("cmu_free_en", cmu_free_en, e_free_en);
            chk("cmu_raddr", cmu_raddr, e_raddr);
            chk("done", done, e_done);
            chk("done_addr", done_addr, e_done_addr);
            chk("free_ack", free_ack, e_free_ack);
            chk("free_count", free_count, e_fc);
            if (cmu_wen && cmu_free_en) chk("strobe_exclusive", 1, 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int n_blk, base;

    initial begin
        for (int i = 0; i < 1024; i++) link[i] = '0;
        rst_n = 1'b0; req = '0; req_len = '0; free_req = 1'b0; free_addr = '0;
        cmu_packet_addr = '0;
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("rst_grant", grant, 0);
        chk("rst_free_count", free_count, 63);
        chk("rst_wen", cmu_wen, 0);
        chk("rst_free_en", cmu_free_en, 0);

        // Port 2, three blocks.
        cmu_packet_addr = 10'h155;
        req_len[2*LEN_W +: LEN_W] = 6'd3;
        req = 4'b0100;
        step(1);
        chk("a_grant", grant, 4'b0100);
        chk("a_wen1", cmu_wen, 1);
        chk("a_len1", cmu_len, 3);
        req = '0;
        step(4);
        chk("a_wen2", cmu_wen, 1);
        chk("a_len2", cmu_len, 2);
        step(4);
        chk("a_len3", cmu_len, 1);
        step(4);
        chk("a_done", done, 1);
        chk("a_done_addr", done_addr, 10'h155);
        chk("a_free_count", free_count, 60);
        step(1);

        // Free chain 5 -> 9 -> 0.
        link[5] = 10'd9; link[9] = '0;
        free_addr = 10'd5; free_req = 1'b1;
        step(1);
        chk("b_free_en1", cmu_free_en, 1);
        chk("b_raddr1", cmu_raddr, 5);
        step(3);
        chk("b_free_en2", cmu_free_en, 1);
        chk("b_raddr2", cmu_raddr, 9);
        step(3);
        chk("b_ack", free_ack, 1);
        chk("b_free_count", free_count, 62);
        free_req = 1'b0;
        step(1);

        // Drain to 2 free blocks, then an oversized request is skipped.
        req_len[3*LEN_W +: LEN_W] = 6'd60;
        req = 4'b1000;
        step(1);
        chk("c_grant3", grant, 4'b1000);
        req = '0;
        step(240);
        chk("c_done60", done, 1);
        chk("c_free_count2", free_count, 2);
        step(1);
        req_len[0 +: LEN_W] = 6'd5;
        req_len[LEN_W +: LEN_W] = 6'd2;
        req = 4'b0011;
        step(1);
        chk("c_grant1", grant, 4'b0010);
        req[1] = 1'b0;
        step(8);
        chk("c_done2", done, 1);
        chk("c_free_count0", free_count, 0);
        step(3);
        chk("c_skip", grant, 0);
        req = '0;

        // Long chain refills and saturates the pool.
        for (int i = 0; i < 64; i++) link[100 + i] = (i == 63) ? '0 : ADDR_W'(101 + i);
        free_addr = 10'd100; free_req = 1'b1;
        step(193);
        chk("c_ack64", free_ack, 1);
        chk("c_free_sat", free_count, 63);
        free_req = 1'b0;
        step(1);

        // Simultaneous free and request: free first, then abort by reset mid-gap.
        link[7] = '0; free_addr = 10'd7; free_req = 1'b1;
        req_len[0 +: LEN_W] = 6'd1; req = 4'b0001;
        step(1);
        chk("d_free_first", cmu_free_en, 1);
        chk("d_no_grant", grant, 0);
        step(3);
        chk("d_ack", free_ack, 1);
        free_req = 1'b0;
        step(2);
        chk("d_grant0", grant, 4'b0001);
        chk("d_wen", cmu_wen, 1);
        req = '0;
        step(2);
        rst_n = 1'b0;
        #1;
        chk("e_grant", grant, 0);
        chk("e_free_count", free_count, 63);
        chk("e_done_addr", done_addr, 0);
        chk("e_wen", cmu_wen, 0);
        step(2);
        rst_n = 1'b1;
        req_len = '0;
        step(1);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            cmu_packet_addr = ADDR_W'($urandom_range(1, 1023));
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 9) == 0) begin
                    req[p] = 1'($urandom_range(0, 1));
                    if (!(m_kind == 1 && m_port == p))
                        req_len[p*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 20));
                end
            end
            if (e_free_ack) begin
                free_req = 1'b0;
            end else if (!free_req && $urandom_range(0, 29) == 0) begin
                n_blk = $urandom_range(1, 4);
                base  = $urandom_range(1, 1000);
                for (int i = 0; i < n_blk; i++)
                    link[base + i] = (i == n_blk - 1) ? '0 : ADDR_W'(base + i + 1);
                free_addr = ADDR_W'(base);
                free_req  = 1'b1;
            end
        end
        req = '0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmu_sched.md
# cmu_sched

Scheduler that shares one `cmu` packet-control allocator between `NUM_PORTS` ingress requesters and one egress free path. It picks an ingress port round-robin and checks that enough free blocks remain. It then drives the `cmu` write strobe once per block with the correct remaining length and returns the head address of the packet chain. Egress frees take priority: the scheduler walks the linked chain through the `cmu` read port and returns every block.

## Interface
- `NUM_PORTS`, 4: ingress requesters.
- `LEN_W`, 6: packet length width, in blocks.
- `ADDR_W`, 10: control-memory address width.
- `FREE_INIT`, 63: free blocks after reset; must equal the `cmu` initial empty count.
- `BLK_GAP`, 4: cycles from one `cmu_wen` pulse to the next; `cmu` needs 4 to relink.
- `RD_LAT`, 2: cycles from driving `cmu_raddr` to a valid `cmu_next_read`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in NUM_PORTS: per-port allocation request, level.
- `req_len` in NUM_PORTS*LEN_W: packed lengths; port i is bits [i*LEN_W +: LEN_W].
- `grant` out NUM_PORTS: one-hot, held while that port is being served.
- `done` out 1: one-cycle pulse, allocation complete.
- `done_addr` out ADDR_W: head address, valid while `done`=1 and held afterward.
- `free_req` in 1: free a chain, level.
- `free_addr` in ADDR_W: head address of the chain to free.
- `free_ack` out 1: one-cycle pulse, whole chain freed.
- `free_count` out LEN_W: scheduler's free-block count.
- `cmu_wen` out 1: block-allocate strobe to `cmu`.
- `cmu_len` out LEN_W: remaining packet length, in blocks.
- `cmu_free_en` out 1: block-free strobe to `cmu`.
- `cmu_raddr` out ADDR_W: read/free address to `cmu`.
- `cmu_packet_addr` in ADDR_W: `cmu` current write block.
- `cmu_next_read` in ADDR_W: `cmu` link of the block at `cmu_raddr`.

## Operation
- FSM states: IDLE, ALLOC, ALLOC_GAP, DONE, FREE_RD, FREE_WAIT, FREE_ACK.
- Eligible port: `req`=1, 0 < `req_len` <= `free_count`. A port with length 0 or length above `free_count` is skipped without a grant; it becomes eligible once enough blocks are free.
- IDLE priority: `free_req` wins over any eligible port.
- IDLE → FREE_RD on a free; latch `free_addr` into the walk register.
- IDLE → ALLOC on an allocation. Pick the first eligible port at or after `rr_ptr`, wrapping, and latch its length into `rem`. Set `grant`; set `rr_ptr` to the granted port + 1, mod NUM_PORTS.
- ALLOC, one cycle:
  - `cmu_wen`=1, `cmu_len`=`rem`.
  - First block only: capture `cmu_packet_addr` as the head.
  - `free_count` -= 1, `rem` -= 1.
  - Next state ALLOC_GAP.
- ALLOC_GAP: wait BLK_GAP-1 cycles. Then go to ALLOC if `rem`≠0, else DONE.
- DONE: `done`=1 and `done_addr`=head for one cycle; clear `grant`; next state IDLE.
- FREE_RD, one cycle: `cmu_raddr`=walk address, `cmu_free_en`=1; `free_count` += 1, saturating at FREE_INIT. Next state FREE_WAIT.
- FREE_WAIT: hold `cmu_raddr` for RD_LAT cycles, then sample `cmu_next_read`.
  - Next = 0: go to FREE_ACK.
  - Otherwise: walk address = next; go to FREE_RD.
- FREE_ACK: `free_ack`=1 for one cycle; next state IDLE. The requester must drop `free_req` in the cycle after `free_ack`.
- Arithmetic: `free_count` never wraps. Decrement happens only after the eligibility check, so it cannot go below 0.

## Timing
- Reset values: all outputs 0, except `free_count`=FREE_INIT. `rr_ptr`=0, state IDLE.
- Allocation latency, from the IDLE sampling edge with `req` to `done`: 1 + L*BLK_GAP cycles for length L.
- First `cmu_wen` appears the cycle after the grant decision. Successive `cmu_wen` pulses are exactly BLK_GAP apart.
- Free latency: (1+RD_LAT) cycles per block, +1 for `free_ack`.
- No preemption: `free_req` raised mid-allocation waits until IDLE and is served before any pending `req`.
- `req` dropped mid-allocation is ignored; the allocation completes. Requesters must hold `req_len` stable while granted.
- `cmu_wen` and `cmu_free_en` are never high in the same cycle.
- Reset mid-operation: abort immediately to reset values. System reset also resets `cmu`, so counts stay consistent.

## Test plan
- Reset → `grant`=0, `free_count`=63, no strobes, IDLE.
- Port 2, `req_len`=3 → `grant`=4'b0100; three `cmu_wen` pulses 4 cycles apart with `cmu_len` 3, 2, 1; `done` at cycle 13; `done_addr` = `cmu_packet_addr` at the first pulse; `free_count`=60.
- Ports 0, 1, 3 all request length 1, held → grants in order 0, 1, 3, 0, and so on, each 5 cycles.
- `free_count`=2; port 0 requests 5, port 1 requests 2 → port 1 granted, port 0 skipped; `free_count` reaches 0.
- `free_req` with chain 5→9→0 → `cmu_free_en` at addr 5 then addr 9; `free_ack` after 7 cycles; `free_count` += 2.
- `free_req` and `req` in the same cycle → free served first; `rst_n` low during ALLOC_GAP → outputs return to reset values asynchronously.
